// File: rtl/parity_frame_rx.sv
// parity_frame_rx
// Receive end of the parity link. It deserialises a frame made of a start bit (0),
// DATA_W data bits sent LSB first, one parity bit and a stop bit (1).
// Parity is recomputed over the received data. The parity result and the stop-bit
// check are reported with a one-cycle data_valid pulse.
// The line is only sampled on clock edges where bit_en is high.

module parity_frame_rx #(
    parameter int DATA_W = 8,
    parameter int ODD    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    // One extra counter bit so the count never wraps inside a frame.
    localparam int              CW      = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0]   LAST    = CW'(DATA_W - 1);
    localparam logic            ODD_BIT = (ODD != 0);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [DATA_W-1:0]   sreg, sreg_n;
    logic                xr, xr_n;
    logic                perr, perr_n;
    logic                load;

    // Frame-tracking state: FSM, bit counter, shift register and running parity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
            xr    <= 1'b0;
            perr  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sreg  <= sreg_n;
            xr    <= xr_n;
            perr  <= perr_n;
        end
    end

    // Next-state logic. Nothing moves unless bit_en is high.
    // Data enters at the MSB and shifts right, so the first bit received ends up in sreg[0].
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sreg_n  = sreg;
        xr_n    = xr;
        perr_n  = perr;
        load    = 1'b0;
        if (bit_en) begin
            case (state)
                IDLE: begin
                    if (!rx) begin
                        state_n = DATA;
                        cnt_n   = '0;
                        xr_n    = 1'b0;
                    end
                end
                DATA: begin
                    sreg_n = {rx, sreg[DATA_W-1:1]};
                    xr_n   = xr ^ rx;
                    cnt_n  = cnt + 1'b1;
                    if (cnt == LAST) begin
                        state_n = PAR;
                    end
                end
                PAR: begin
                    perr_n  = xr ^ rx ^ ODD_BIT;
                    state_n = STOP;
                end
                STOP: begin
                    load    = 1'b1;
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Result registers. They update on the stop-bit edge and hold until the next frame completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= load;
            if (load) begin
                data_out   <= sreg;
                parity_err <= perr;
                frame_err  <= ~rx;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx
// Directed and random frames are driven into an even-parity and an odd-parity receiver.
// Both receivers share the same line. Each result is compared against a frame-level model:
// expected data is the word sent, parity error is the ones-count rule, and frame error is
// set when the stop bit is low.

module tb_parity_frame_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_en;
    logic         rx;
    logic [W-1:0] data_out, data_out_o;
    logic         dv, pe, fe, busy;
    logic         dv_o, pe_o, fe_o, busy_o;

    int tests  = 0;
    int fails  = 0;
    int frames = 0;
    int pulses = 0;
    int pulses_o = 0;

    parity_frame_rx #(.DATA_W(W), .ODD(0)) dut (
        .clk(clk), .rst(rst), .bit_en(bit_en), .rx(rx),
        .data_out(data_out), .data_valid(dv), .parity_err(pe),
        .frame_err(fe), .busy(busy)
    );

    parity_frame_rx #(.DATA_W(W), .ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .bit_en(bit_en), .rx(rx),
        .data_out(data_out_o), .data_valid(dv_o), .parity_err(pe_o),
        .frame_err(fe_o), .busy(busy_o)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Count data_valid pulses. Sampling is done mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (dv)   pulses++;
        if (dv_o) pulses_o++;
    end

    // The parity check fails when the ones count of data plus the parity bit does not match the scheme.
    function automatic logic model_perr(logic [W-1:0] d, logic p, int odd);
        int ones;
        ones = int'(p);
        for (int i = 0; i < W; i++) ones += int'(d[i]);
        return (ones % 2) != odd;
    endfunction

    task automatic checkOutput(string tag, logic obs, logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkWord(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkCount(string tag, int obs, int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic strobe(logic b);
        @(negedge clk);
        rx     = b;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'($urandom % 2);
        end
    endtask

    task automatic applyStimulus(logic [W-1:0] d, logic p, logic s, int gap);
        strobe(1'b0);
        checkOutput("busy_after_start", busy, 1'b1);
        for (int i = 0; i < W; i++) begin
            idle(gap);
            strobe(d[i]);
        end
        idle(gap);
        strobe(p);
        idle(gap);
        strobe(s);
        frames++;
    endtask

    task automatic expectFrame(logic [W-1:0] d, logic p, logic s);
        checkOutput("dv_even", dv, 1'b1);
        checkWord("data_even", data_out, d);
        checkOutput("perr_even", pe, model_perr(d, p, 0));
        checkOutput("ferr_even", fe, !s);
        checkOutput("busy_done", busy, 1'b0);
        checkOutput("dv_odd", dv_o, 1'b1);
        checkWord("data_odd", data_out_o, d);
        checkOutput("perr_odd", pe_o, model_perr(d, p, 1));
        checkOutput("ferr_odd", fe_o, !s);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
        checkOutput("dv_drop_even", dv, 1'b0);
        checkOutput("dv_drop_odd", dv_o, 1'b0);
        checkCount("pulses_even", pulses, frames);
        checkCount("pulses_odd", pulses_o, frames);
    endtask

    task automatic checkCleared(string tag);
        checkWord({tag, "_data"}, data_out, '0);
        checkOutput({tag, "_dv"}, dv, 1'b0);
        checkOutput({tag, "_perr"}, pe, 1'b0);
        checkOutput({tag, "_ferr"}, fe, 1'b0);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkWord({tag, "_data_odd"}, data_out_o, '0);
        checkOutput({tag, "_busy_odd"}, busy_o, 1'b0);
    endtask

    // Directed cases first, then random frames. All steps run back to back in this one block.
    initial begin
        logic [W-1:0] rd;
        logic         rp, rs;
        int           rg;

        rst    = 1'b1;
        bit_en = 1'b0;
        rx     = 1'b1;
        repeat (2) @(negedge clk);
        checkCleared("reset");
        rst = 1'b0;

        applyStimulus(8'hA5, 1'b0, 1'b1, 0);
        expectFrame(8'hA5, 1'b0, 1'b1);
        settle();

        applyStimulus(8'hA5, 1'b1, 1'b1, 0);
        expectFrame(8'hA5, 1'b1, 1'b1);
        settle();

        applyStimulus(8'h01, 1'b1, 1'b0, 0);
        expectFrame(8'h01, 1'b1, 1'b0);
        applyStimulus(8'h5A, 1'b0, 1'b1, 0);
        expectFrame(8'h5A, 1'b0, 1'b1);
        settle();

        applyStimulus(8'hA5, 1'b0, 1'b1, 3);
        expectFrame(8'hA5, 1'b0, 1'b1);
        settle();

        strobe(1'b0);
        for (int i = 0; i < 4; i++) strobe(1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkCleared("midrst");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h3C, 1'b0, 1'b1, 0);
        expectFrame(8'h3C, 1'b0, 1'b1);
        settle();

        applyStimulus(8'hFF, 1'b0, 1'b1, 0);
        expectFrame(8'hFF, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b1, 1'b1, 0);
        expectFrame(8'h00, 1'b1, 1'b1);
        settle();

        for (int n = 0; n < 20; n++) begin
            rd = W'($urandom);
            rp = 1'($urandom % 2);
            rs = 1'(($urandom % 4) != 0);
            rg = int'($urandom_range(0, 2));
            applyStimulus(rd, rp, rs, rg);
            expectFrame(rd, rp, rs);
        end
        settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
